// File: rtl/id_stim_pkg.sv
// Shared types and defaults for the instruction-decode stimulus sequencer.
// Holds the sequencer state encoding, the default boot PC and the PC helper.
package id_stim_pkg;

    localparam logic [63:0] BOOT_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Entries are 4-byte instructions laid out contiguously from the base PC.
    function automatic logic [63:0] entry_pc(input logic [63:0] base, input logic [63:0] idx);
        return base + {idx[61:0], 2'b00};
    endfunction

endpackage

// File: rtl/id_stim_mem.sv
// Program store for the stimulus sequencer: one write port, one async read port.
// Contents are deliberately not reset so a loaded program survives a run abort.
module id_stim_mem #(
    parameter int DEPTH = 16,
    parameter int ILEN = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [ILEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [ILEN-1:0] rd_data
);

    logic [ILEN-1:0] mem [DEPTH];

    // Synchronous write of one program entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/id_stim_seq.sv
// Instruction-decode stimulus sequencer: plays a loaded program into a decode
// stage, counts issue acknowledgements and reports cycle/stall statistics.
// Optional feature: define ID_STIM_SEQ_TIMEOUT_EN to bound the DRAIN wait.
//
// Handshakes: an entry transfers on a rising edge where fetch_valid_o and
// fetch_ready_i are both 1; while valid is high and ready low, fetch_instr_o
// and fetch_pc_o hold their value. Valid never depends on ready. On the issue
// side issue_ack_o simply mirrors issue_valid_i while a run is active.
module id_stim_seq
    import id_stim_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter int          ILEN    = 32,
    parameter logic [63:0] BOOT_PC = BOOT_PC_DEFAULT,
    parameter int          CNT_W   = 32,
    parameter int          TIMEOUT = 1024,
    localparam int         AW      = $clog2(DEPTH),
    localparam int         NW      = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NW-1:0]    num_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [ILEN-1:0]  wr_instr_i,
    output logic             fetch_valid_o,
    output logic [ILEN-1:0]  fetch_instr_o,
    output logic [63:0]      fetch_pc_o,
    input  logic             fetch_ready_i,
    input  logic             issue_valid_i,
    output logic             issue_ack_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic [CNT_W-1:0] stall_o,
    output logic [NW-1:0]    issued_o,
    output logic [2:0]       dbg_state
);

    state_e            state, state_nx;
    logic [NW-1:0]     num_q;
    logic [NW-1:0]     sent;
    logic [NW-1:0]     issued;
    logic [CNT_W-1:0]  cycles;
    logic [CNT_W-1:0]  stall;
    logic [NW-1:0]     num_clamped;
    logic [ILEN-1:0]   rd_data;
    logic              in_run;
    logic              active;
    logic              xfer;
    logic              ack;
    logic              issue_done;
    logic              launch;

    assign in_run      = (state == RUN);
    assign active      = (state == RUN) || (state == DRAIN);
    assign xfer        = in_run && fetch_ready_i;
    assign ack         = issue_valid_i && active;
    assign launch      = (state == IDLE) && start_i;
    assign num_clamped = (num_i > NW'(DEPTH)) ? NW'(DEPTH) : num_i;
    // Completion counts an ack landing in this very cycle.
    assign issue_done  = (issued == num_q) || (ack && ((issued + NW'(1)) == num_q));

    id_stim_mem #(
        .DEPTH(DEPTH),
        .ILEN (ILEN)
    ) u_mem (
        .clk    (clk_i),
        .wr_en  (wr_en_i && !busy_o),
        .wr_addr(wr_addr_i),
        .wr_data(wr_instr_i),
        .rd_addr(sent[AW-1:0]),
        .rd_data(rd_data)
    );

`ifdef ID_STIM_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          timeout_q;
    logic          timeout_hit;

    // Counts consecutive DRAIN cycles and latches the timeout flag until the next start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == DRAIN) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end
            if (launch) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
`ifdef ID_STIM_SEQ_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                state_nx = (num_q == '0) ? DONE : RUN;
            end
            RUN: begin
                if (xfer && ((sent + NW'(1)) == num_q)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (issue_done) begin
                    state_nx = DONE;
                end
`ifdef ID_STIM_SEQ_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_nx    = DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Run bookkeeping: latched length, progress counters and statistics.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            num_q  <= '0;
            sent   <= '0;
            issued <= '0;
            cycles <= '0;
            stall  <= '0;
        end else if (launch) begin
            num_q  <= num_clamped;
            sent   <= '0;
            issued <= '0;
            cycles <= '0;
            stall  <= '0;
        end else begin
            if (xfer) begin
                sent <= sent + NW'(1);
            end
            if (ack && (issued != num_q)) begin
                issued <= issued + NW'(1);
            end
            if (active && (cycles != '1)) begin
                cycles <= cycles + CNT_W'(1);
            end
            if (in_run && !fetch_ready_i && (stall != '1)) begin
                stall <= stall + CNT_W'(1);
            end
        end
    end

    // Output decode; fetch data is forced to zero outside RUN.
    always_comb begin
        fetch_valid_o = in_run;
        fetch_instr_o = '0;
        fetch_pc_o    = '0;
        if (in_run) begin
            fetch_instr_o = rd_data;
            fetch_pc_o    = entry_pc(BOOT_PC, 64'(sent));
        end
    end

    assign issue_ack_o = ack;
    assign flush_o     = (state == FLUSH);
    assign busy_o      = (state == FLUSH) || active;
    assign done_o      = (state == DONE);
    assign cycles_o    = cycles;
    assign stall_o     = stall;
    assign issued_o    = issued;
    assign dbg_state   = state;

endmodule

// File: tb/tb_id_stim_seq.sv
// Self-checking bench for id_stim_seq with a run-level reference model.
// Honours ID_STIM_SEQ_TIMEOUT_EN when the DUT is built with it.
module tb_id_stim_seq;

    localparam int DEPTH      = 8;
    localparam int ILEN       = 32;
    localparam int CNT_W      = 32;
    localparam int TB_TIMEOUT = 8;
    localparam int AW         = $clog2(DEPTH);
    localparam int NW         = AW + 1;
    localparam logic [63:0] BOOT = 64'h8000_0000;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [NW-1:0]    num_i;
    logic             wr_en_i;
    logic [AW-1:0]    wr_addr_i;
    logic [ILEN-1:0]  wr_instr_i;
    logic             fetch_valid_o;
    logic [ILEN-1:0]  fetch_instr_o;
    logic [63:0]      fetch_pc_o;
    logic             fetch_ready_i;
    logic             issue_valid_i;
    logic             issue_ack_o;
    logic             flush_o;
    logic             busy_o;
    logic             done_o;
    logic             timeout_o;
    logic [CNT_W-1:0] cycles_o;
    logic [CNT_W-1:0] stall_o;
    logic [NW-1:0]    issued_o;
    logic [2:0]       dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    logic [ILEN-1:0] model_mem [DEPTH];
    logic [ILEN-1:0] exp_q[$];

    id_stim_seq #(
        .DEPTH  (DEPTH),
        .ILEN   (ILEN),
        .CNT_W  (CNT_W),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .num_i        (num_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_instr_i   (wr_instr_i),
        .fetch_valid_o(fetch_valid_o),
        .fetch_instr_o(fetch_instr_o),
        .fetch_pc_o   (fetch_pc_o),
        .fetch_ready_i(fetch_ready_i),
        .issue_valid_i(issue_valid_i),
        .issue_ack_o  (issue_ack_o),
        .flush_o      (flush_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .cycles_o     (cycles_o),
        .stall_o      (stall_o),
        .issued_o     (issued_o),
        .dbg_state    (dbg_state)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Driver: write one program entry while the sequencer is idle.
    task automatic load(input int addr, input logic [ILEN-1:0] data);
        @(negedge clk);
        wr_en_i    = 1'b1;
        wr_addr_i  = AW'(addr);
        wr_instr_i = data;
        @(negedge clk);
        wr_en_i    = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic load_all_random();
        for (int a = 0; a < DEPTH; a++) load(a, $urandom);
    endtask

    // Plays one run and checks every cycle against the run-level model:
    // entries k=0..n-1 go out in order at BOOT+4k, a drain follows the last
    // transfer and ends once min(acks, n) == n.
    task automatic play(input int n_req, input int rdy_pct, input int iv_pct, input bit iv_follow,
                        input int stall_entry, input int stall_len, input bit poke);
        int n, sent, iss, cyc, stl, hold, dcnt, guard;
        bit fin, rdy, iv, prev_xfer, was_drain, exp_to;
        n = (n_req > DEPTH) ? DEPTH : n_req;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(model_mem[k]);
        sent = 0; iss = 0; cyc = 0; stl = 0; hold = 0; dcnt = 0; guard = 0;
        prev_xfer = 1'b0; exp_to = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        num_i   = NW'(n_req);
        @(negedge clk);
        start_i = 1'b0; fetch_ready_i = 1'b0; issue_valid_i = 1'b0;
        #1;
        n_cmp++;
        if (flush_o !== 1'b1 || busy_o !== 1'b1 || fetch_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: flush=%b busy=%b valid=%b required 1 1 0", flush_o, busy_o, fetch_valid_o);
        end
        fin = (n == 0);
        while (!fin && guard < 400) begin
            guard++;
            @(negedge clk);
            start_i = 1'b0; wr_en_i = 1'b0;
            if (sent == stall_entry && hold < stall_len) rdy = 1'b0;
            else rdy = ($urandom_range(1, 100) <= rdy_pct);
            iv = iv_follow ? prev_xfer : ($urandom_range(1, 100) <= iv_pct);
            if (poke && cyc == 1) begin
                start_i = 1'b1; num_i = NW'(1);
                wr_en_i = 1'b1; wr_addr_i = '0; wr_instr_i = ~model_mem[0];
            end
            fetch_ready_i = rdy; issue_valid_i = iv;
            #1;
            was_drain = (sent == n);
            n_cmp++;
            if (fetch_valid_o !== !was_drain) begin
                n_fail++;
                $display("FAIL fetch_valid: got %b required %b (sent=%0d)", fetch_valid_o, !was_drain, sent);
            end
            if (!was_drain) begin
                n_cmp++;
                if (fetch_pc_o !== BOOT + 64'(sent) * 4) begin
                    n_fail++;
                    $display("FAIL fetch_pc: got %h required %h", fetch_pc_o, BOOT + 64'(sent) * 4);
                end
                n_cmp++;
                if (fetch_instr_o !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL fetch_instr: got %h required %h (entry %0d)", fetch_instr_o, exp_q[0], sent);
                end
            end
            n_cmp++;
            if (issue_ack_o !== iv || busy_o !== 1'b1 || done_o !== 1'b0 || flush_o !== 1'b0) begin
                n_fail++;
                $display("FAIL active_ctrl: ack=%b busy=%b done=%b flush=%b required %b 1 0 0",
                         issue_ack_o, busy_o, done_o, flush_o, iv);
            end
            cyc++;
            prev_xfer = 1'b0;
            if (!was_drain) begin
                if (rdy) begin
                    void'(exp_q.pop_front());
                    sent++;
                    prev_xfer = 1'b1;
                end else begin
                    stl++;
                    if (sent == stall_entry) hold++;
                end
            end
            if (iv && iss < n) iss++;
            if (was_drain) begin
                dcnt++;
                if (iss == n) fin = 1'b1;
`ifdef ID_STIM_SEQ_TIMEOUT_EN
                else if (dcnt == TB_TIMEOUT) begin
                    fin = 1'b1;
                    exp_to = 1'b1;
                end
`endif
            end
        end
        if (!fin) begin
            n_cmp++;
            n_fail++;
            $display("FAIL play_guard: run of %0d did not finish within %0d cycles", n, guard);
        end
        @(negedge clk);
        start_i = 1'b0; wr_en_i = 1'b0; fetch_ready_i = 1'b0; issue_valid_i = 1'b0;
        #1;
        n_cmp++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || fetch_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle: done=%b busy=%b valid=%b required 1 0 0", done_o, busy_o, fetch_valid_o);
        end
        n_cmp++;
        if (cycles_o !== CNT_W'(cyc) || stall_o !== CNT_W'(stl) || issued_o !== NW'(iss)) begin
            n_fail++;
            $display("FAIL run_counters: cycles=%0d stall=%0d issued=%0d required %0d %0d %0d",
                     cycles_o, stall_o, issued_o, cyc, stl, iss);
        end
        n_cmp++;
        if (timeout_o !== exp_to) begin
            n_fail++;
            $display("FAIL timeout_flag: got %b required %b", timeout_o, exp_to);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done_o !== 1'b0 || cycles_o !== CNT_W'(cyc) || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL after_done: done=%b cycles=%0d state=%0d required 0 %0d 0", done_o, cycles_o, dbg_state, cyc);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; num_i = '0; wr_en_i = 1'b0; wr_addr_i = '0;
        wr_instr_i = '0; fetch_ready_i = 1'b1; issue_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({fetch_valid_o, issue_ack_o, flush_o, busy_o, done_o, timeout_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 000000",
                     {fetch_valid_o, issue_ack_o, flush_o, busy_o, done_o, timeout_o});
        end
        n_cmp++;
        if (fetch_pc_o !== '0 || fetch_instr_o !== '0 || cycles_o !== '0 || stall_o !== '0 || issued_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: pc=%h instr=%h cycles=%0d stall=%0d issued=%0d required all 0",
                     fetch_pc_o, fetch_instr_o, cycles_o, stall_o, issued_o);
        end
        @(negedge clk);
        rst_i = 1'b0; fetch_ready_i = 1'b0; issue_valid_i = 1'b0;
    endtask

    task automatic test_basic();
        for (int a = 0; a < 4; a++) load(a, 32'h0000_0013 + (a << 20));
        play(4, 100, 0, 1'b1, -1, 0, 1'b0);
        n_cmp++;
        if (cycles_o !== 32'd5 || issued_o !== 4'd4) begin
            n_fail++;
            $display("FAIL basic_totals: cycles=%0d issued=%0d required 5 4", cycles_o, issued_o);
        end
    endtask

    task automatic test_stall();
        play(3, 100, 0, 1'b1, 1, 2, 1'b0);
        n_cmp++;
        if (stall_o !== 32'd2 || cycles_o !== 32'd6) begin
            n_fail++;
            $display("FAIL stall_totals: stall=%0d cycles=%0d required 2 6", stall_o, cycles_o);
        end
    endtask

    task automatic test_zero();
        play(0, 100, 50, 1'b0, -1, 0, 1'b0);
        n_cmp++;
        if (cycles_o !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_cycles: got %0d required 0", cycles_o);
        end
    endtask

    task automatic test_abort();
        load_all_random();
        @(negedge clk);
        start_i = 1'b1; num_i = NW'(4);
        @(negedge clk);
        start_i = 1'b0; fetch_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (fetch_pc_o !== BOOT + 64'd8 || fetch_instr_o !== model_mem[2]) begin
            n_fail++;
            $display("FAIL abort_pre: pc=%h instr=%h required %h %h", fetch_pc_o, fetch_instr_o, BOOT + 64'd8, model_mem[2]);
        end
        #1 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({fetch_valid_o, flush_o, busy_o, done_o} !== 4'b0 || dbg_state !== 3'd0 ||
            fetch_pc_o !== '0 || cycles_o !== '0 || issued_o !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: flags=%b state=%0d pc=%h cycles=%0d issued=%0d required all 0",
                     {fetch_valid_o, flush_o, busy_o, done_o}, dbg_state, fetch_pc_o, cycles_o, issued_o);
        end
        @(negedge clk);
        rst_i = 1'b0; fetch_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (done_o !== 1'b0 || flush_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet: done=%b flush=%b busy=%b required 0 0 0", done_o, flush_o, busy_o);
            end
        end
        play(4, 100, 70, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        play(5, 80, 60, 1'b0, -1, 0, 1'b1);
        play(5, 100, 100, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_clamp();
        play(DEPTH + 5, 90, 80, 1'b0, -1, 0, 1'b0);
        n_cmp++;
        if (issued_o !== NW'(DEPTH)) begin
            n_fail++;
            $display("FAIL clamp_issued: got %0d required %0d", issued_o, DEPTH);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            load_all_random();
            play($urandom_range(0, DEPTH + 3), $urandom_range(30, 100), $urandom_range(30, 90),
                 1'b0, -1, 0, 1'b0);
        end
    endtask

    task automatic test_timeout();
`ifdef ID_STIM_SEQ_TIMEOUT_EN
        play(2, 100, 0, 1'b0, -1, 0, 1'b0);
        n_cmp++;
        if (timeout_o !== 1'b1 || cycles_o !== CNT_W'(2 + TB_TIMEOUT)) begin
            n_fail++;
            $display("FAIL timeout_run: timeout=%b cycles=%0d required 1 %0d", timeout_o, cycles_o, 2 + TB_TIMEOUT);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_abort();
        test_busy_ignore();
        test_clamp();
        test_random();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stim_seq.md
ID_STIM_SEQ -- requirements
Module: id_stim_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, program entries (power of two, >=2).
REQ-002 SHALL have parameter ILEN, default 32, instruction width.
REQ-003 SHALL have parameter BOOT_PC, default 64'h8000_0000, PC of entry 0.
REQ-004 SHALL have parameter CNT_W, default 32, counter width.
REQ-005 SHALL have parameter TIMEOUT, default 1024, drain-timeout cycles.
REQ-006 SHALL have clk_i  in  1  single clock, all state on rising edge.
REQ-007 SHALL have rst_i  in  1  asynchronous, active-high reset.
REQ-008 SHALL have start_i  in  1  run request pulse; num_i  in  $clog2(DEPTH)+1  entries to play.
REQ-009 SHALL have wr_en_i  in  1, wr_addr_i  in  $clog2(DEPTH), wr_instr_i  in  ILEN  program load port.
REQ-010 SHALL have fetch_valid_o  out  1, fetch_instr_o  out  ILEN, fetch_pc_o  out  64, fetch_ready_i  in  1  decode-input handshake.
REQ-011 SHALL have issue_valid_i  in  1, issue_ack_o  out  1  decode-output handshake.
REQ-012 SHALL have flush_o  out  1  decode flush pulse.
REQ-013 SHALL have busy_o, done_o, timeout_o  out  1 each; cycles_o, stall_o  out  CNT_W; issued_o  out  $clog2(DEPTH)+1.

Function
REQ-014 FSM states SHALL be IDLE, FLUSH, RUN, DRAIN, DONE.
REQ-015 IDLE: start_i=1 SHALL latch num_i, clear sent/issued/cycles/stall/timeout, go FLUSH.
REQ-016 FLUSH SHALL last exactly one cycle with flush_o=1, then go RUN; if latched num=0, go DONE instead.
REQ-017 RUN SHALL drive fetch_valid_o=1, fetch_instr_o=mem[sent], fetch_pc_o=BOOT_PC+4*sent.
REQ-018 An entry SHALL transfer on fetch_valid_o&fetch_ready_i; sent increments; fetch outputs SHALL stay stable while valid&!ready.
REQ-019 RUN SHALL go DRAIN in the cycle after sent reaches num; fetch_valid_o=0 outside RUN.
REQ-020 issue_ack_o SHALL equal issue_valid_i combinationally in RUN and DRAIN, 0 otherwise; each ack increments issued (saturating at num).
REQ-021 DRAIN SHALL go DONE when issued==num, including the same cycle as the last ack.
REQ-022 cycles_o SHALL count every cycle in RUN and DRAIN, saturating at all-ones; stall_o SHALL count RUN cycles with valid&!ready, saturating.
REQ-023 done_o SHALL pulse one cycle on DONE entry; DONE SHALL return to IDLE next cycle; counters hold until next start.
REQ-024 busy_o SHALL be 1 in FLUSH, RUN, DRAIN.
REQ-025 start_i and wr_en_i SHALL be ignored while busy_o=1; writes in IDLE/DONE SHALL update mem[wr_addr_i] next edge.
REQ-026 num_i>DEPTH SHALL be clamped to DEPTH.

Reset
REQ-027 rst_i SHALL asynchronously force IDLE; all outputs 0, all counters 0; program memory not reset.
REQ-028 rst_i mid-run SHALL abort without done_o; flush_o SHALL not be asserted by reset.

Configuration
REQ-029 Macro ID_STIM_SEQ_TIMEOUT_EN defined: DRAIN counter SHALL go DONE with timeout_o=1 after TIMEOUT cycles without reaching num.
REQ-030 Macro undefined: DRAIN SHALL wait indefinitely; timeout_o tied 0; no timeout counter synthesised.

Structure
REQ-031 State enum and BOOT_PC default SHALL live in a shared package id_stim_pkg.
REQ-032 Program storage SHALL be one sub-module id_stim_mem (1W/1R async-read register file).

Verification
REQ-033 Load 4 entries, num=4, ready=1, issue_valid 1 cycle after each transfer -> PCs 8000_0000..8000_000C, issued=4, done_o one pulse, timeout_o=0.
REQ-034 num=3, fetch_ready_i low 2 cycles on entry 1 -> entry 1 held stable, stall_o=2, cycles_o=5 (+drain).
REQ-035 num=0 -> flush_o pulse, done_o next cycle, cycles_o=0.
REQ-036 With ID_STIM_SEQ_TIMEOUT_EN, TIMEOUT=8, no issue_valid_i -> done_o and timeout_o=1 exactly 8 DRAIN cycles after DRAIN entry.
REQ-037 rst_i asserted mid-RUN after 2 transfers -> immediate IDLE, all outputs 0, no done_o; fresh start replays from entry 0.
REQ-038 start_i and wr_en_i pulsed during RUN -> no restart, memory contents unchanged.
